// File: rtl/vending_pkg.sv
// Shared encodings, item/price table constants and state type for the vending controller.
// No logic of its own; helpers are pure combinational functions.
// No flow control involved.
package vending_pkg;

  localparam logic [2:0] CTRL_IDLE   = 3'b001;
  localparam logic [2:0] CTRL_PRICE  = 3'b010;
  localparam logic [2:0] CTRL_OOS    = 3'b011;
  localparam logic [2:0] CTRL_INSERT = 3'b100;
  localparam logic [2:0] CTRL_REFUND = 3'b101;

  localparam logic [7:0] ITEM_A2 = 8'hA2;
  localparam logic [7:0] ITEM_B3 = 8'hB3;
  localparam logic [7:0] ITEM_D5 = 8'hD5;
  localparam logic [7:0] ITEM_E8 = 8'hE8;

  localparam logic [3:0] PRICE_A2 = 4'd5;
  localparam logic [3:0] PRICE_B3 = 4'd4;
  localparam logic [3:0] PRICE_D5 = 4'd9;
  localparam logic [3:0] PRICE_E8 = 4'd3;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_QUARTER = 2'b01;
  localparam logic [1:0] COIN_HALF    = 2'b10;
  localparam logic [1:0] COIN_DOLLAR  = 2'b11;

  localparam logic [4:0] MAX_CREDIT = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY2,
    ST_DISP_PRICE,
    ST_DISP_OOS,
    ST_INSERT,
    ST_REFUND
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] price;
    logic [1:0] index;
  } price_t;

  function automatic logic [4:0] coin_units(input logic [1:0] v);
    case (v)
      COIN_QUARTER: coin_units = 5'd1;
      COIN_HALF:    coin_units = 5'd2;
      COIN_DOLLAR:  coin_units = 5'd4;
      default:      coin_units = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] ctrl_of(input state_t s);
    case (s)
      ST_DISP_PRICE: ctrl_of = CTRL_PRICE;
      ST_DISP_OOS:   ctrl_of = CTRL_OOS;
      ST_INSERT:     ctrl_of = CTRL_INSERT;
      ST_REFUND:     ctrl_of = CTRL_REFUND;
      default:       ctrl_of = CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/vending_price_lut.sv
// Item code to {valid, price, index} lookup.
// Purely combinational, zero latency.
// No flow control.
module vending_price_lut
  import vending_pkg::*;
(
  input  logic [7:0] code,
  output price_t     info
);

  always_comb begin
    info = '0;
    case (code)
      ITEM_A2: info = '{valid: 1'b1, price: PRICE_A2, index: 2'd0};
      ITEM_B3: info = '{valid: 1'b1, price: PRICE_B3, index: 2'd1};
      ITEM_D5: info = '{valid: 1'b1, price: PRICE_D5, index: 2'd2};
      ITEM_E8: info = '{valid: 1'b1, price: PRICE_E8, index: 2'd3};
      default: info = '0;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Vending sequencer: key selection, stock check, coin credit, vend and refund.
// All outputs registered; a decision on cycle N inputs appears on cycle N+1.
// No backpressure: strobes are consumed or rejected in the cycle they arrive.
module vending_controller
  import vending_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int PRICE_HOLD     = 100000000,
  parameter int OOS_HOLD       = 100000000,
  parameter int REFUND_HOLD    = 150000000,
  parameter int INSERT_TIMEOUT = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic [3:0] stock_ok,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       cancel,
  output logic [2:0] control,
  output logic [7:0] itemcode,
  output logic [3:0] insertedmoney,
  output logic [3:0] refundmoney,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       coin_reject
);

  localparam logic [CNT_W-1:0] PRICE_LAST   = CNT_W'(PRICE_HOLD - 1);
  localparam logic [CNT_W-1:0] OOS_LAST     = CNT_W'(OOS_HOLD - 1);
  localparam logic [CNT_W-1:0] REFUND_LAST  = CNT_W'(REFUND_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INSERT_TIMEOUT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       control_n;
  logic [7:0]       itemcode_n;
  logic [3:0]       ins_n, ref_n;
  logic             vend_n, reject_n;
  logic [1:0]       vend_item_n;
  logic [7:0]       lut_code;
  price_t           lut;
  logic [4:0]       sum;
  logic             coin_ok;

  // In KEY2 the candidate code is the first nibble plus the key arriving now.
  assign lut_code = (state == ST_KEY2) ? {itemcode[7:4], key_data} : itemcode;

  vending_price_lut u_lut (
    .code (lut_code),
    .info (lut)
  );

  assign sum = {1'b0, insertedmoney} + coin_units(coin_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      control       <= CTRL_IDLE;
      itemcode      <= '0;
      insertedmoney <= '0;
      refundmoney   <= '0;
      vend          <= 1'b0;
      vend_item     <= '0;
      coin_reject   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      control       <= control_n;
      itemcode      <= itemcode_n;
      insertedmoney <= ins_n;
      refundmoney   <= ref_n;
      vend          <= vend_n;
      vend_item     <= vend_item_n;
      coin_reject   <= reject_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CNT_W'(1);
    itemcode_n  = itemcode;
    ins_n       = insertedmoney;
    ref_n       = refundmoney;
    vend_n      = 1'b0;
    vend_item_n = vend_item;
    reject_n    = coin_valid && (state != ST_INSERT);
    coin_ok     = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (key_valid) begin
          itemcode_n = {key_data, 4'h0};
          state_n    = ST_KEY2;
        end
      end

      ST_KEY2: begin
        cnt_n = '0;
        if (key_valid) begin
          if (!lut.valid) begin
            itemcode_n = '0;
            state_n    = ST_IDLE;
          end else begin
            itemcode_n = {itemcode[7:4], key_data};
            state_n    = stock_ok[lut.index] ? ST_DISP_PRICE : ST_DISP_OOS;
          end
        end
      end

      ST_DISP_PRICE: begin
        if (cnt == PRICE_LAST) begin
          state_n = ST_INSERT;
          ins_n   = '0;
          cnt_n   = '0;
        end
      end

      ST_DISP_OOS: begin
        if (cnt == OOS_LAST) begin
          state_n    = ST_IDLE;
          itemcode_n = '0;
          cnt_n      = '0;
        end
      end

      ST_INSERT: begin
        if (cancel) begin
          ref_n    = insertedmoney;
          state_n  = ST_REFUND;
          cnt_n    = '0;
          reject_n = coin_valid;
        end else begin
          if (coin_valid) begin
            if (coin_value == COIN_NONE || sum > MAX_CREDIT) begin
              reject_n = 1'b1;
            end else begin
              coin_ok = 1'b1;
              ins_n   = sum[3:0];
              cnt_n   = '0;
              if (sum >= {1'b0, lut.price}) begin
                vend_n      = 1'b1;
                vend_item_n = lut.index;
                ref_n       = sum[3:0] - lut.price;
                state_n     = ST_REFUND;
              end
            end
          end
          // An accepted coin restarts the idle window, so timeout only fires without one.
          if (!coin_ok && cnt == TIMEOUT_LAST) begin
            ref_n   = insertedmoney;
            state_n = ST_REFUND;
            cnt_n   = '0;
          end
        end
      end

      ST_REFUND: begin
        if (cnt == REFUND_LAST) begin
          state_n    = ST_IDLE;
          ins_n      = '0;
          ref_n      = '0;
          itemcode_n = '0;
          cnt_n      = '0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    control_n = ctrl_of(state_n);
  end

endmodule

// File: tb/tb_vending_controller.sv
// Directed and randomized checks of vending_controller against a transaction-level model.
module tb_vending_controller;

  localparam int PH = 3;
  localparam int OH = 4;
  localparam int RH = 5;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_data = '0;
  logic [3:0] stock_ok = 4'hF;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = '0;
  logic       cancel = 1'b0;
  logic [2:0] control;
  logic [7:0] itemcode;
  logic [3:0] insertedmoney;
  logic [3:0] refundmoney;
  logic       vend;
  logic [1:0] vend_item;
  logic       coin_reject;

  int nerr = 0;
  int nchk = 0;

  logic [7:0] codes  [4] = '{8'hA2, 8'hB3, 8'hD5, 8'hE8};
  int         prices [4] = '{5, 4, 9, 3};

  int         idx, credit, units, n;
  logic [1:0] v;
  logic [3:0] st;
  bit         done;

  vending_controller #(
    .CNT_W          (32),
    .PRICE_HOLD     (PH),
    .OOS_HOLD       (OH),
    .REFUND_HOLD    (RH),
    .INSERT_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_data      (key_data),
    .stock_ok      (stock_ok),
    .coin_valid    (coin_valid),
    .coin_value    (coin_value),
    .cancel        (cancel),
    .control       (control),
    .itemcode      (itemcode),
    .insertedmoney (insertedmoney),
    .refundmoney   (refundmoney),
    .vend          (vend),
    .vend_item     (vend_item),
    .coin_reject   (coin_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_data  = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic drop(input logic [1:0] c);
    coin_valid = 1'b1;
    coin_value = c;
    step();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [7:0] code);
    press(code[7:4]);
    press(code[3:0]);
  endtask

  // Counts consecutive sampled cycles showing control mode c (bounded).
  task automatic wait_hold(input logic [2:0] c, input int exp_len, input string tag);
    int k;
    k = 0;
    while (control === c && k < 200) begin
      k++;
      step();
    end
    chk(tag, k, exp_len);
  endtask

  initial begin
    #12;
    chk("rst_control", control, 1);
    chk("rst_itemcode", itemcode, 0);
    chk("rst_inserted", insertedmoney, 0);
    chk("rst_refund", refundmoney, 0);
    chk("rst_vend", vend, 0);
    chk("rst_vend_item", vend_item, 0);
    chk("rst_reject", coin_reject, 0);
    step();
    rst_n = 1'b1;
    step();

    // Coin in IDLE is returned
    drop(2'b11);
    chk("idle_coin_reject", coin_reject, 1);
    chk("idle_coin_credit", insertedmoney, 0);

    // A2: price hold, dollar, quarter
    press(4'hA);
    chk("key1_itemcode", itemcode, 8'hA0);
    chk("key1_control", control, 1);
    press(4'h2);
    chk("a2_itemcode", itemcode, 8'hA2);
    chk("a2_control", control, 2);
    wait_hold(3'd2, PH, "a2_price_hold");
    chk("a2_insert", control, 4);
    chk("a2_credit0", insertedmoney, 0);
    press(4'h5);
    chk("insert_key_ignored", itemcode, 8'hA2);
    drop(2'b11);
    chk("a2_credit4", insertedmoney, 4);
    chk("a2_novend", vend, 0);
    drop(2'b01);
    chk("a2_vend", vend, 1);
    chk("a2_vend_item", vend_item, 0);
    chk("a2_refund", refundmoney, 0);
    chk("a2_ctrl_refund", control, 5);
    step();
    chk("a2_vend_oneshot", vend, 0);
    wait_hold(3'd5, RH - 1, "a2_refund_hold");
    chk("a2_exit_ctrl", control, 1);
    chk("a2_exit_item", itemcode, 0);
    chk("a2_exit_credit", insertedmoney, 0);
    chk("a2_exit_refund", refundmoney, 0);

    // D5: three dollars
    select(8'hD5);
    wait_hold(3'd2, PH, "d5_price_hold");
    drop(2'b11);
    drop(2'b11);
    chk("d5_credit8", insertedmoney, 8);
    drop(2'b11);
    chk("d5_vend", vend, 1);
    chk("d5_vend_item", vend_item, 2);
    chk("d5_refund", refundmoney, 3);
    wait_hold(3'd5, RH, "d5_refund_hold");

    // E8: half then dollar
    select(8'hE8);
    wait_hold(3'd2, PH, "e8_price_hold");
    drop(2'b10);
    chk("e8_credit2", insertedmoney, 2);
    drop(2'b00);
    chk("e8_null_coin_reject", coin_reject, 1);
    chk("e8_null_coin_credit", insertedmoney, 2);
    drop(2'b11);
    chk("e8_vend", vend, 1);
    chk("e8_vend_item", vend_item, 3);
    chk("e8_refund", refundmoney, 3);
    wait_hold(3'd5, RH, "e8_refund_hold");

    // B3 out of stock
    stock_ok = 4'b1101;
    select(8'hB3);
    chk("oos_control", control, 3);
    chk("oos_itemcode", itemcode, 8'hB3);
    wait_hold(3'd3, OH, "oos_hold");
    chk("oos_exit_ctrl", control, 1);
    chk("oos_exit_item", itemcode, 0);
    chk("oos_novend", vend, 0);
    stock_ok = 4'hF;

    // Cancel and coin together
    select(8'hB3);
    wait_hold(3'd2, PH, "b3_price_hold");
    drop(2'b10);
    chk("b3_credit2", insertedmoney, 2);
    cancel     = 1'b1;
    coin_valid = 1'b1;
    coin_value = 2'b01;
    step();
    cancel     = 1'b0;
    coin_valid = 1'b0;
    chk("cancel_reject", coin_reject, 1);
    chk("cancel_refund", refundmoney, 2);
    chk("cancel_control", control, 5);
    chk("cancel_novend", vend, 0);
    wait_hold(3'd5, RH, "cancel_refund_hold");

    // Timeout after an accepted coin
    select(8'hE8);
    wait_hold(3'd2, PH, "to_price_hold");
    drop(2'b01);
    wait_hold(3'd4, TO, "timeout_len");
    chk("timeout_ctrl", control, 5);
    chk("timeout_refund", refundmoney, 1);
    chk("timeout_novend", vend, 0);
    wait_hold(3'd5, RH, "timeout_refund_hold");

    // Asynchronous reset during INSERT with credit 3
    select(8'hA2);
    wait_hold(3'd2, PH, "rst_price_hold");
    drop(2'b10);
    drop(2'b01);
    chk("rst_credit3", insertedmoney, 3);
    rst_n = 1'b0;
    #2;
    chk("arst_control", control, 1);
    chk("arst_itemcode", itemcode, 0);
    chk("arst_credit", insertedmoney, 0);
    chk("arst_refund", refundmoney, 0);
    step();
    rst_n = 1'b1;
    step();

    // Invalid code C7
    select(8'hC7);
    chk("c7_control", control, 1);
    chk("c7_itemcode", itemcode, 0);

    // Randomized transactions against a credit/price model
    for (int t = 0; t < 12; t++) begin
      idx = $urandom_range(0, 3);
      st  = 4'($urandom);
      stock_ok = st;
      select(codes[idx]);
      if (!st[idx]) begin
        chk("rnd_oos_ctrl", control, 3);
        wait_hold(3'd3, OH, "rnd_oos_hold");
        chk("rnd_oos_item", itemcode, 0);
      end else begin
        chk("rnd_price_ctrl", control, 2);
        wait_hold(3'd2, PH, "rnd_price_hold");
        credit = 0;
        done   = 1'b0;
        n      = 0;
        while (!done && n < 30) begin
          n++;
          if ($urandom_range(0, 9) == 0) begin
            cancel = 1'b1;
            step();
            cancel = 1'b0;
            chk("rnd_cancel_ctrl", control, 5);
            chk("rnd_cancel_refund", refundmoney, credit);
            chk("rnd_cancel_novend", vend, 0);
            done = 1'b1;
          end else begin
            v = 2'($urandom_range(0, 3));
            units = (v == 2'd1) ? 1 : (v == 2'd2) ? 2 : (v == 2'd3) ? 4 : 0;
            drop(v);
            if (units == 0 || credit + units > 12) begin
              chk("rnd_reject", coin_reject, 1);
              chk("rnd_reject_credit", insertedmoney, credit);
            end else if (credit + units >= prices[idx]) begin
              chk("rnd_vend", vend, 1);
              chk("rnd_vend_item", vend_item, idx);
              chk("rnd_change", refundmoney, credit + units - prices[idx]);
              chk("rnd_vend_ctrl", control, 5);
              done = 1'b1;
            end else begin
              credit += units;
              chk("rnd_credit", insertedmoney, credit);
              chk("rnd_accept", coin_reject, 0);
              chk("rnd_novend", vend, 0);
            end
          end
        end
        wait_hold(3'd5, RH, "rnd_refund_hold");
      end
      chk("rnd_idle", control, 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
